piso_serializer: RTL



---
 rtl/piso_serializer_pkg.sv | 18 +
 rtl/piso_hold_reg.sv | 33 +++
 rtl/piso_serializer.sv | 91 +++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer: FSM state
// encoding and the bit-counter width helper.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..n-1; callers guarantee n >= 2.
  function automatic int CLOG2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding buffer in front of the shifter. Accepts a word on
// valid/ready and releases it when the shifter pulses take.
module piso_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             take,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full
);

  // Ready comes straight from the flag register, never from din_valid.
  assign din_ready = !hold_full;

  // take and accept are mutually exclusive: take needs a full buffer,
  // accept needs an empty one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (take) begin
      hold_full <= 1'b0;
    end else if (din_valid && !hold_full) begin
      hold      <= din;
      hold_full <= 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out front end: buffers one word, shifts the current one
// out one bit per clock with frame_start/done strobes, gapless back-to-back.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int            CW   = CLOG2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] sr, sr_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             take;

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .take      (take),
    .hold      (hold),
    .hold_full (hold_full)
  );

  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    take    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          sr_d    = hold;
          cnt_d   = '0;
          take    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        cnt_d = cnt + CW'(1);
        if (cnt == LAST) begin
          cnt_d = '0;
          if (hold_full) begin
            sr_d = hold;
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      sr    <= sr_d;
      cnt   <= cnt_d;
    end
  end

  // After WIDTH zero-filling shifts sr is all zero, so sout reads 0 in IDLE
  // straight from the register without any gating.
  assign sout        = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign sout_valid  = (state == ST_SHIFT);
  assign frame_start = sout_valid && (cnt == '0);
  assign done        = sout_valid && (cnt == LAST);

endmodule
